// File: rtl/nv_fifo_ctrl_16x272.sv
// nv_fifo_ctrl_16x272: valid/ready FIFO sequencer for an external
// 16x272 1R1W RAM with a registered read address and a combinational dout.
// The RAM read address register always tracks rd_ptr, so rd_pd is simply
// the RAM output and a pop exposes the next entry without a bubble.

module nv_fifo_ctrl_16x272 #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int DW       = 272,
    parameter int AFULL_TH = 12
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          wr_afull,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW:0]   count,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [DW-1:0] ram_di,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AFULL_C = (AW+1)'(AFULL_TH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          prime_pend_r;
    logic          afull_r;

    logic [AW-1:0] wr_ptr_nxt_s;
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [AW:0]   count_nxt_s;
    logic          afull_nxt_s;

    logic          full_s;
    logic          wr_prdy_s;
    logic          rd_pvld_s;
    logic          push_s;
    logic          pop_s;

    // Handshake decode; a full FIFO refuses writes even when a pop is under way.
    assign full_s    = (count_r == DEPTH_C);
    assign wr_prdy_s = ~full_s & nvdla_core_rstn;
    assign rd_pvld_s = (count_r != '0) & ~prime_pend_r;
    assign push_s    = wr_pvld & wr_prdy_s;
    assign pop_s     = rd_pvld_s & rd_prdy;

    assign wr_prdy  = wr_prdy_s;
    assign rd_pvld  = rd_pvld_s;
    assign rd_pd    = ram_dout;
    assign count    = count_r;
    assign wr_afull = afull_r;

    // Write port is a straight pass-through of the accepted payload.
    assign ram_we = push_s;
    assign ram_wa = wr_ptr_r;
    assign ram_di = wr_pd;

    // Read-address sequencing: load rd_ptr once after reset, then the
    // successor of rd_ptr on every pop so the RAM is already looking ahead.
    assign ram_re = pop_s | prime_pend_r;
    assign ram_ra = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;

    // Next-state computation for pointers, occupancy and almost-full flag.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        afull_nxt_s  = (count_r >= AFULL_C);

        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // State registers; reset discards contents and re-arms read-address priming.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            prime_pend_r <= 1'b1;
            afull_r      <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            count_r      <= count_nxt_s;
            prime_pend_r <= 1'b0;
            afull_r      <= afull_nxt_s;
        end
    end

    nv_fifo_ctrl_16x272_chk #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_chk (
        .clk     (nvdla_core_clk),
        .rst_n   (nvdla_core_rstn),
        .count   (count_r),
        .push    (push_s),
        .rd_pvld (rd_pvld_s),
        .rd_prdy (rd_prdy),
        .rd_pd   (ram_dout)
    );

endmodule

// Simulation checker: occupancy bound, no push at full, stable stalled data.
module nv_fifo_ctrl_16x272_chk #(
    parameter int AW    = 4,
    parameter int DW    = 272,
    parameter int DEPTH = 16
) (
    input logic          clk,
    input logic          rst_n,
    input logic [AW:0]   count,
    input logic          push,
    input logic          rd_pvld,
    input logic          rd_prdy,
    input logic [DW-1:0] rd_pd
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count <= DEPTH_C);

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == DEPTH_C)));

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (rd_pvld && !rd_prdy) |=> $stable(rd_pd));

endmodule

// File: doc/nv_fifo_ctrl_16x272.md
Name: nv_fifo_ctrl_16x272

Overview:
- Flow-control sequencer that turns one nv_ram_rws_16x272 instance (1R1W, registered read address, combinational dout) into a 16-entry, 272-bit valid/ready FIFO.
- Owns write/read pointers, occupancy, RAM port sequencing and post-reset read-address priming.
- The RAM instance is external; this block drives its ports.
- Used wherever a core pipe stage needs a small 272b skid/decoupling buffer.

Parameters:
- DEPTH, 16, number of entries; must equal RAM depth, power of two.
- AW, 4, address width, log2(DEPTH).
- DW, 272, payload width; must equal RAM width.
- AFULL_TH, 12, occupancy at or above which wr_afull asserts (1..DEPTH).

Ports:
- nvdla_core_clk  input  1  core clock, single clock domain.
- nvdla_core_rstn  input  1  asynchronous active-low reset.
- wr_pvld  input  1  write payload valid.
- wr_prdy  output  1  write ready.
- wr_pd  input  DW  write payload.
- wr_afull  output  1  occupancy >= AFULL_TH.
- rd_pvld  output  1  read payload valid.
- rd_prdy  input  1  read ready.
- rd_pd  output  DW  read payload.
- count  output  AW+1  current occupancy, 0..DEPTH.
- ram_we  output  1  RAM write enable.
- ram_wa  output  AW  RAM write address.
- ram_di  output  DW  RAM write data.
- ram_re  output  1  RAM read-address load enable.
- ram_ra  output  AW  RAM read address.
- ram_dout  input  DW  RAM read data, M[ra_d], combinational.

Behaviour:
- Reset (async assert, sync deassert via flops) clears wr_ptr, rd_ptr and count to 0, sets prime_pend=1, and drops rd_pvld to 0.
- Outputs during reset: wr_prdy=0, wr_afull=0, count=0, ram_we=0. ram_re and ram_ra are don't-care.
- Push: push = wr_pvld & wr_prdy.
  - wr_prdy = !full & !in_reset; full = (count==DEPTH).
  - No write-through when full, even if a pop occurs in the same cycle.
- Write path (combinational pass-through):
  - ram_we = push.
  - ram_wa = wr_ptr.
  - ram_di = wr_pd.
  - wr_ptr increments on push and wraps modulo DEPTH (15 -> 0).
- Pop: pop = rd_pvld & rd_prdy.
  - rd_ptr increments on pop and wraps modulo DEPTH.
- Read addressing invariant: the RAM's internal ra_d always equals rd_ptr once priming is complete.
  - ram_re = pop | prime_pend.
  - ram_ra = pop ? rd_ptr+1 (wrapped) : rd_ptr.
  - prime_pend clears after its first cycle out of reset.
- Read data and valid:
  - rd_pd = ram_dout (no extra register).
  - rd_pvld = (count!=0) & !prime_pend.
- Latency:
  - A push at edge t is visible as rd_pvld=1 from cycle t+1 when the FIFO was empty (M written and count incremented on the same edge).
  - Pop-to-next-data is 0 bubbles; back-to-back pops at 1 per cycle.
- Occupancy (AW+1 bits, registered):
  - count += push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - Underflow and overflow are impossible by construction.
  - wr_afull = (count >= AFULL_TH), registered.
- Stability:
  - Slot rd_ptr is never written while occupied, because push is blocked at full.
  - Therefore rd_pd is stable while rd_pvld & !rd_prdy.
  - rd_pd may change only after a pop.
- Reset mid-operation: all stored entries are discarded (RAM contents ignored), pointers return to 0, and priming reruns.
- Assertions (sim only):
  - count <= DEPTH.
  - rd_pd stable while stalled.
  - no push when full.

Test Plan:
- Reset release with FIFO empty, wr_pvld=1 payload 0xA5..A5 (272b) at cycle 3:
  - ram_re=1 with ram_ra=0 in the first cycle out of reset.
  - rd_pvld=1 and rd_pd=0xA5..A5 at cycle 4.
  - count=1.
- Fill 16 entries with incrementing values, rd_prdy=0:
  - wr_prdy=0 after the 16th push and count=16.
  - wr_afull=1 from the cycle after count reaches 12.
  - A 17th wr_pvld is not accepted.
- Full FIFO, assert wr_pvld and rd_prdy together for 1 cycle:
  - Pop only; count 16->15.
  - wr_prdy=1 next cycle.
- Streaming of 40 words with wr_pvld=rd_prdy=1 continuously:
  - Output order exactly 0..39 with no bubbles after the first.
  - wr_ptr and rd_ptr wrap 15->0 twice.
- Stall: hold rd_prdy=0 for 5 cycles while pushing 3 words:
  - rd_pd stays at the first word.
  - Word order is preserved on release.
- Assert nvdla_core_rstn=0 with count=7:
  - count=0, rd_pvld=0, wr_prdy=0 immediately.
  - After release, the FIFO behaves as empty and priming ram_re fires.
